// File: rtl/cube_loader.sv
// cube_loader: processor-side feeder for the cube solver.
//
// Collects the scrambled cube state from 32-bit register writes into a
// shadow register, copies it onto a stable bus d when a solve is started,
// pulses run for one cycle, then waits for the solver's finish flag while
// counting cycles. The finishing step is latched; a solve that runs too
// long is flagged as a timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data word write into the shadow register
//   start               request a solve (needs all words written)
//   clear               synchronous abort back to IDLE, clears status
//   solver_q            solver finish flag (level)
//   solver_step         solver's current step
//   d                   cube state to the solver, stable during a solve
//   run                 one-cycle start strobe to the solver
//   busy/done/timeout   status decoded from the state
//   word_mask           which shadow words have been written
//   wr_err              sticky: write attempted while busy
//   final_step          solver_step captured at finish
//   cycles              WAIT-state cycle count of the last/ongoing solve
module cube_loader #(
    parameter int                 WORD_W  = 32,
    parameter int                 DATA_W  = 120,
    parameter int                 NWORDS  = 4,
    parameter int                 CNT_W   = 24,
    parameter logic [CNT_W-1:0]   TIMEOUT = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              clear,
    input  logic              solver_q,
    input  logic [3:0]        solver_step,
    output logic [DATA_W-1:0] d,
    output logic              run,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [NWORDS-1:0] word_mask,
    output logic              wr_err,
    output logic [3:0]        final_step,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [2:0] {IDLE, RUN, WAIT, DONE, TOUT} state_t;

    // Last WAIT count value before the timeout edge.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t                         state_q, state_d;
    logic [NWORDS-1:0][WORD_W-1:0]  shadow_q, shadow_d;
    logic [NWORDS-1:0]              mask_q, mask_d;
    logic                           err_q, err_d;
    logic [DATA_W-1:0]              d_q, d_d;
    logic [3:0]                     step_q, step_d;
    logic [CNT_W-1:0]               cyc_q, cyc_d;

    logic [NWORDS*WORD_W-1:0]       shadow_flat;
    logic                           unused_hi;

    assign shadow_flat = shadow_q;
    // Top bits of the last word are kept in the shadow but never reach d.
    assign unused_hi   = ^shadow_flat[NWORDS*WORD_W-1:DATA_W];

    assign busy       = (state_q == RUN) || (state_q == WAIT);
    assign run        = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign timeout    = (state_q == TOUT);
    assign d          = d_q;
    assign word_mask  = mask_q;
    assign wr_err     = err_q;
    assign final_step = step_q;
    assign cycles     = cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
            d_q      <= '0;
            step_q   <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            d_q      <= d_d;
            step_q   <= step_d;
            cyc_q    <= cyc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        err_d    = err_q;
        d_d      = d_q;
        step_d   = step_q;
        cyc_d    = cyc_q;

        if (clear) begin
            // Abort wins over everything else; d and shadow are kept.
            state_d = IDLE;
            mask_d  = '0;
            err_d   = 1'b0;
            step_d  = '0;
            cyc_d   = '0;
        end else begin
            if (wr_en) begin
                if (busy) begin
                    err_d = 1'b1;
                end else begin
                    shadow_d[wr_idx] = wr_data;
                    mask_d[wr_idx]   = 1'b1;
                end
            end

            case (state_q)
                IDLE, DONE, TOUT: begin
                    // Uses the pre-write mask and shadow, so a same-cycle
                    // write lands in shadow but not in this solve.
                    if (start && (&mask_q)) begin
                        state_d = RUN;
                        d_d     = shadow_flat[DATA_W-1:0];
                        cyc_d   = '0;
                    end
                end
                RUN: state_d = WAIT;
                WAIT: begin
                    if (solver_q) begin
                        state_d = DONE;
                        step_d  = solver_step;
                    end else begin
                        cyc_d = sat_inc(cyc_q);
                        if (cyc_q == TMO_LAST) state_d = TOUT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_loader.sv
// Directed bench for cube_loader. A default-timeout instance covers the
// loading/solve behaviour; a second instance with TIMEOUT=16 covers the
// timeout boundary. Both share the same stimulus.
module tb_cube_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [1:0]   wr_idx;
    logic [31:0]  wr_data;
    logic         start;
    logic         clear;
    logic         solver_q;
    logic [3:0]   solver_step;

    logic [119:0] d, d16;
    logic         run, run16, busy, busy16, done, done16, tout, tout16;
    logic [3:0]   mask, mask16, fstep, fstep16;
    logic         werr, werr16;
    logic [23:0]  cyc, cyc16;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [119:0] D_FULL = 120'h444444_33333333_22222222_11111111;

    always #5 clk = ~clk;

    cube_loader u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .start(start), .clear(clear),
        .solver_q(solver_q), .solver_step(solver_step),
        .d(d), .run(run), .busy(busy), .done(done), .timeout(tout),
        .word_mask(mask), .wr_err(werr), .final_step(fstep), .cycles(cyc)
    );

    cube_loader #(.TIMEOUT(24'd16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .start(start), .clear(clear),
        .solver_q(solver_q), .solver_step(solver_step),
        .d(d16), .run(run16), .busy(busy16), .done(done16), .timeout(tout16),
        .word_mask(mask16), .wr_err(werr16), .final_step(fstep16), .cycles(cyc16)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic finish_solve(input logic [3:0] step);
        solver_q = 1'b1; solver_step = step;
        tick();
        solver_q = 1'b0;
    endtask

    task automatic load_full();
        wr(2'd0, 32'h11111111);
        wr(2'd1, 32'h22222222);
        wr(2'd2, 32'h33333333);
        wr(2'd3, 32'hAA444444);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        start = 1'b0; clear = 1'b0; solver_q = 1'b0; solver_step = '0;
        #12;
        check("rst_d", d, 0);
        check("rst_flags", {run, busy, done, tout, werr}, 0);
        check("rst_mask", mask, 0);
        check("rst_fstep_cyc", {fstep, cyc}, 0);
        rst_n = 1'b1;
        tick();

        // 1: full load, start, run strobe
        load_full();
        check("t1_mask", mask, 4'hF);
        check("t1_run_before", run, 0);
        pulse_start();
        check("t1_run", run, 1);
        check("t1_busy", busy, 1);
        check("t1_d", d, D_FULL);
        tick();
        check("t1_run_off", run, 0);
        check("t1_busy_wait", busy, 1);
        finish_solve(4'h2);
        check("t1_done", done, 1);

        // 2: incomplete mask, start ignored
        pulse_clear();
        check("t2_mask_clr", mask, 0);
        wr(2'd0, 32'h11111111);
        wr(2'd1, 32'h22222222);
        wr(2'd3, 32'hAA444444);
        check("t2_mask", mask, 4'hB);
        pulse_start();
        check("t2_run", run, 0);
        check("t2_busy", busy, 0);
        tick();
        check("t2_run2", {run, busy, done, werr}, 0);

        // 3: 37 WAIT cycles then finish with step 9
        pulse_clear();
        load_full();
        pulse_start();
        tick();
        check("t3_cyc0", cyc, 0);
        for (int i = 0; i < 37; i++) tick();
        check("t3_cyc37_wait", cyc, 37);
        check("t3_busy", busy, 1);
        finish_solve(4'h9);
        check("t3_done", done, 1);
        check("t3_fstep", fstep, 4'h9);
        check("t3_cyc", cyc, 37);
        check("t3_busy_off", busy, 0);
        tick();
        check("t3_hold", {done, fstep, cyc}, {1'b1, 4'h9, 24'd37});

        // 4: TIMEOUT=16 instance times out after 16 WAIT cycles
        pulse_clear();
        load_full();
        pulse_start();
        check("t4_run16", run16, 1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("t4_tout_pre", tout16, 0);
        check("t4_cyc15", cyc16, 15);
        tick();
        check("t4_tout", tout16, 1);
        check("t4_cyc16", cyc16, 16);
        check("t4_done0", done16, 0);
        check("t4_busy0", busy16, 0);
        // re-run from TOUT; finish coinciding with the timeout edge
        pulse_start();
        check("t4_rerun", run16, 1);
        check("t4_rerun_cyc", cyc16, 0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        finish_solve(4'h5);
        check("t4_tie_done", done16, 1);
        check("t4_tie_tout", tout16, 0);
        check("t4_tie_fstep", fstep16, 4'h5);
        check("t4_tie_cyc", cyc16, 15);

        // 5: write during WAIT is discarded and flagged
        pulse_clear();
        load_full();
        pulse_start();
        tick();
        wr(2'd2, 32'hDEADBEEF);
        check("t5_werr", werr, 1);
        check("t5_busy", busy, 1);
        check("t5_d", d, D_FULL);
        check("t5_mask", mask, 4'hF);
        finish_solve(4'h1);
        check("t5_done", done, 1);
        check("t5_werr_sticky", werr, 1);
        pulse_start();
        check("t5_run2", run, 1);
        check("t5_shadow_w2", d, D_FULL);
        pulse_clear();
        check("t5_clr_werr", werr, 0);
        check("t5_clr_mask", mask, 0);
        check("t5_clr_stat", {busy, done, fstep, cyc}, 0);
        check("t5_clr_d_kept", d, D_FULL);

        // 6: start and write in the same cycle
        load_full();
        start = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_data = 32'h55555555;
        tick();
        start = 1'b0; wr_en = 1'b0;
        check("t6_run", run, 1);
        check("t6_d_old", d[31:0], 32'h11111111);
        check("t6_mask", mask, 4'hF);
        check("t6_werr", werr, 0);
        tick();
        finish_solve(4'h3);
        check("t6_done", done, 1);
        pulse_start();
        check("t6_run2", run, 1);
        check("t6_d_new", d, {D_FULL[119:32], 32'h55555555});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/cube_loader.md
Name: cube_loader

Overview:
- Upstream feeder for the cube-solver top. It collects the 120-bit scrambled cube state from a 32-bit register-write interface.
- It presents the state on a stable 120-bit bus, issues the one-cycle run strobe, and then waits for the solver's finish flag.
- It latches the final step, counts solve cycles and flags a timeout.
- It is the block the processor-side register logic talks to; the solver sees only d and run.

Parameters:
- WORD_W, 32, width of the write-data word
- DATA_W, 120, width of the cube-state bus
- NWORDS, 4, words per cube state (ceil(DATA_W/WORD_W))
- CNT_W, 24, width of the solve-cycle counter
- TIMEOUT, 24'hFFFFFF, WAIT cycles before timeout is declared

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  word write strobe
- wr_idx  in  2  word index; 0 is the least-significant word
- wr_data  in  WORD_W  word payload
- start  in  1  request a solve (single-cycle pulse)
- clear  in  1  synchronous abort/clear to IDLE
- solver_q  in  1  solver finish flag (level)
- solver_step  in  4  solver's current step output
- d  out  DATA_W  cube state to the solver, registered
- run  out  1  one-cycle start strobe to the solver
- busy  out  1  high in RUN and WAIT
- done  out  1  high in DONE
- timeout  out  1  high in TOUT
- word_mask  out  NWORDS  bit i set once word i has been written
- wr_err  out  1  sticky: a write was attempted while busy
- final_step  out  4  solver_step captured at finish
- cycles  out  CNT_W  WAIT-state cycle count of the last or ongoing solve

Behaviour:
- Reset (async, rst_n=0): every output and the internal shadow register are 0, and state=IDLE.
- Shadow register:
  - shadow holds NWORDS×WORD_W bits.
  - A write with wr_en=1 in IDLE, DONE or TOUT stores wr_data into shadow word wr_idx and sets word_mask[wr_idx] on the next edge.
  - Word 3 contributes only bits [23:0]; bits [31:24] are stored but never reach d.
  - Writing the same word twice overwrites it; the mask bit stays set.
  - A write while busy=1 is discarded and sets wr_err. wr_err is cleared only by clear or reset.
- FSM states: IDLE, RUN, WAIT, DONE, TOUT.
- IDLE / DONE / TOUT:
  - start=1 with word_mask all ones moves to RUN. On that edge, d <= shadow[DATA_W-1:0] and cycles <= 0.
  - start with an incomplete mask is ignored (no error flag).
  - start and wr_en in the same cycle: the mask test uses the pre-write mask, and d captures the pre-write shadow. The write still lands in shadow.
- RUN:
  - run=1 for exactly this one cycle; next state is WAIT unconditionally.
  - start is ignored while busy.
- WAIT:
  - cycles increments by 1 per cycle, saturating at all-ones.
  - solver_q=1 moves to DONE and captures final_step <= solver_step on the same edge.
  - Otherwise, when cycles == TIMEOUT-1 and solver_q=0, move to TOUT.
  - If solver_q and the timeout condition coincide, DONE wins.
- DONE / TOUT:
  - Hold final_step, cycles and d.
  - A new start (mask still full) re-runs with the current shadow. The mask is not auto-cleared.
- clear=1, any state:
  - Next state IDLE; word_mask, wr_err, final_step and cycles go to 0.
  - d and shadow are retained.
  - clear has priority over start, wr_en and solver_q in the same cycle.
  - Mid-solve clear does not stop the solver. The system must reset the solver separately before a new start.
- Latency:
  - start edge to run=1: 1 cycle.
  - solver_q=1 to done=1: 1 cycle.
- d changes only on the accepted-start edge, so it is stable for the whole solve.

Test Plan:
1. Write words 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'hAA444444, then pulse start.
   - word_mask=4'hF before start.
   - d=120'h444444_33333333_22222222_11111111.
   - run high for exactly 1 cycle, one cycle after start.
2. Write only words 0, 1, 3, then pulse start -> state stays IDLE, run never asserts, busy=0.
3. Full load, start; hold solver_q=0 for 37 WAIT cycles, then solver_q=1 with solver_step=4'h9.
   - Next cycle: done=1, final_step=9, cycles=37.
4. TIMEOUT=16 override, start, solver_q held 0 -> timeout=1 after 16 WAIT cycles; cycles=16; done=0.
5. During WAIT, wr_en=1 with wr_idx=2, wr_data=32'hDEADBEEF.
   - wr_err=1; shadow word 2 unchanged; d unchanged.
   - A later clear drops wr_err to 0 and word_mask to 0.
6. In the same cycle in IDLE, assert start and a write to word 0 of 32'h55555555 (mask previously full, word 0 = 32'h11111111).
   - Run proceeds with d[31:0]=32'h11111111.
   - shadow word 0 = 32'h55555555.
   - A second start after DONE gives d[31:0]=32'h55555555.
